fb_rect_writer: RTL and testbench

Framebuffer write engine: the producer side of the 640x480, 12-bit-per-pixel video memory that the VGA scan-out reads from. It accepts rectangle-fill commands over a valid/ready handshake, clips each rectangle to the visible area, and emits one pixel write per granted cycle. Write address uses the scan-out's linear layout (addr = y*640 + x). It sits between the drawing/control logic and the memory write port, behind the memory arbiter's grant.

---
 rtl/fb_rect_writer.sv | 131 +++++++++++++
 tb/tb_fb_rect_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the 640x480 RGB444 framebuffer.
// Clips each command to the visible area and emits one pixel write per granted cycle, in raster order.
module fb_rect_writer #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              wr_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = 10;
    localparam int unsigned EW = CW + 1;

    typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     lx, ly, lw, lh;
    logic [DATA_W-1:0] color;
    logic [EW-1:0]     x_end, y_end;
    logic [CW-1:0]     cur_x, cur_y;
    logic [ADDR_W-1:0] row_base;

    // Clip arithmetic at 11 bits so x+w / y+h never wrap
    logic [EW-1:0]     sum_x, sum_y, x_end_c, y_end_c, next_x_c, next_y_c;
    logic              empty_c, row_last_c, last_c;
    logic [ADDR_W-1:0] base_c;

    assign sum_x      = EW'(lx) + EW'(lw);
    assign sum_y      = EW'(ly) + EW'(lh);
    assign x_end_c    = (sum_x > EW'(H_RES)) ? EW'(H_RES) : sum_x;
    assign y_end_c    = (sum_y > EW'(V_RES)) ? EW'(V_RES) : sum_y;
    assign empty_c    = (EW'(lx) >= EW'(H_RES)) || (EW'(ly) >= EW'(V_RES))
                        || (lw == '0) || (lh == '0);
    assign base_c     = ADDR_W'(ly) * ADDR_W'(H_RES);
    assign next_x_c   = EW'(cur_x) + EW'(1);
    assign next_y_c   = EW'(cur_y) + EW'(1);
    assign row_last_c = (next_x_c >= x_end);
    assign last_c     = row_last_c && (next_y_c >= y_end);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we       <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            lx       <= '0;
            ly       <= '0;
            lw       <= '0;
            lh       <= '0;
            color    <= '0;
            x_end    <= '0;
            y_end    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            row_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        lx    <= cmd_x;
                        ly    <= cmd_y;
                        lw    <= cmd_w;
                        lh    <= cmd_h;
                        color <= cmd_color;
                        state <= CLIP;
                    end
                end
                CLIP: begin
                    if (empty_c) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x_end    <= x_end_c;
                        y_end    <= y_end_c;
                        cur_x    <= lx;
                        cur_y    <= ly;
                        row_base <= base_c;
                        we       <= 1'b1;
                        wr_addr  <= base_c + ADDR_W'(lx);
                        wr_data  <= color;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    // Outputs only move on a granted cycle, so a stall holds them
                    if (wr_ready) begin
                        if (last_c) begin
                            we    <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (row_last_c) begin
                            cur_x    <= lx;
                            cur_y    <= cur_y + CW'(1);
                            row_base <= row_base + ADDR_W'(H_RES);
                            wr_addr  <= row_base + ADDR_W'(H_RES) + ADDR_W'(lx);
                        end else begin
                            cur_x   <= cur_x + CW'(1);
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: directed commands push hand-computed writes,
// a negedge monitor pops and compares every granted write and checks stall stability.
module tb_fb_rect_writer;

    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [11:0] cmd_color;
    logic        wr_ready;
    logic        we;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;

    fb_rect_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_ready  (wr_ready),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   nwrites = 0;
    int   last_wr_cyc = -100;
    int   last_done_cyc = -100;
    logic stall_prev = 1'b0;
    wr_t  held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int addr, input int data);
        wr_t e;
        e.addr = 19'(addr);
        e.data = 12'(data);
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected write per granted cycle, checks held outputs during stalls
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_we", int'(we), 1);
                check("stall_addr", int'(wr_addr), int'(held.addr));
                check("stall_data", int'(wr_data), int'(held.data));
            end
            if (we && wr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", int'(wr_addr), -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wr_addr), int'(e.addr));
                    check("wr_data", int'(wr_data), int'(e.data));
                end
                nwrites++;
                last_wr_cyc = cyc;
            end
            if (done) last_done_cyc = cyc;
            stall_prev = we && !wr_ready;
            held.addr  = wr_addr;
            held.data  = wr_data;
        end
    end

    // Present a command (called just after a posedge) and wait for its accepting cycle
    task automatic issue(input int x, input int y, input int w, input int h, input int c,
                         output int t_acc);
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 12'(c);
        cmd_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) check("done_timeout", 0, 1);
    endtask

    // Wait for done, check latency, write count and cmd_ready return; ends just after a posedge
    task automatic expect_done(input int t, input int lat, input int n, input int w0);
        int dc;
        wait_done(dc);
        check("done_latency", dc - t, lat);
        if (n > 0) check("done_after_last_write", dc - last_wr_cyc, 1);
        check("write_count", nwrites - w0, n);
        @(negedge clk);
        check("ready_after_done", int'(cmd_ready), 1);
        check("busy_after_done", int'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, t2, w0;
        logic [6:0] pat;
        rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_addr", int'(wr_addr), 0);
        check("rst_data", int'(wr_data), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;

        // Basic 3x2 fill at (10,20)
        w0 = nwrites;
        issue(10, 20, 3, 2, 12'hF00, t);
        cmd_valid = 1'b0;
        push(12810, 12'hF00); push(12811, 12'hF00); push(12812, 12'hF00);
        push(13450, 12'hF00); push(13451, 12'hF00); push(13452, 12'hF00);
        expect_done(t, 8, 6, w0);

        // Bottom-right corner clip
        w0 = nwrites;
        issue(638, 479, 5, 4, 12'h0AB, t);
        cmd_valid = 1'b0;
        push(307198, 12'h0AB); push(307199, 12'h0AB);
        expect_done(t, 4, 2, w0);

        // Empty commands
        w0 = nwrites; issue(5, 5, 0, 3, 12'h111, t); cmd_valid = 1'b0; expect_done(t, 2, 0, w0);
        w0 = nwrites; issue(5, 5, 3, 0, 12'h222, t); cmd_valid = 1'b0; expect_done(t, 2, 0, w0);
        w0 = nwrites; issue(640, 5, 2, 2, 12'h333, t); cmd_valid = 1'b0; expect_done(t, 2, 0, w0);
        w0 = nwrites; issue(5, 480, 2, 2, 12'h444, t); cmd_valid = 1'b0; expect_done(t, 2, 0, w0);

        // Backpressure: 4x1 at (100,5) with grant pattern 1,0,0,1,0,1,1
        w0 = nwrites;
        issue(100, 5, 4, 1, 12'h0F0, t);
        cmd_valid = 1'b0;
        push(3300, 12'h0F0); push(3301, 12'h0F0); push(3302, 12'h0F0); push(3303, 12'h0F0);
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1 wr_ready = pat[i];
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        expect_done(t, 9, 4, w0);

        // Back-to-back: second command queued behind the first with cmd_valid held
        issue(0, 0, 2, 1, 12'h0F0, t);
        push(0, 12'h0F0); push(1, 12'h0F0);
        check("busy_window", int'(busy), 1);
        issue(639, 0, 3, 2, 12'h00F, t2);
        w0 = nwrites;
        cmd_valid = 1'b0;
        check("b2b_accept_after_done", t2 - last_done_cyc, 1);
        check("b2b_accept_gap", t2 - t, 5);
        push(639, 12'h00F); push(1279, 12'h00F);
        expect_done(t2, 4, 2, w0 - 0);

        // Reset in the middle of a 100x100 fill after 37 writes
        w0 = nwrites;
        issue(200, 100, 100, 100, 12'h5A5, t);
        cmd_valid = 1'b0;
        for (int i = 0; i < 37; i++) push(64200 + i, 12'h5A5);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (nwrites - w0 >= 37) break;
        end
        #1 rst = 1'b1;
        #1;
        check("rst_mid_we", int'(we), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_writes", nwrites - w0, 37);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rel_ready", int'(cmd_ready), 1);
        check("rst_rel_done", int'(done), 0);
        @(posedge clk);
        #1;
        w0 = nwrites;
        issue(0, 0, 1, 1, 12'h123, t);
        cmd_valid = 1'b0;
        push(0, 12'h123);
        expect_done(t, 3, 1, w0);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
